// File: rtl/data_mem_bridge.sv
// data_mem_bridge: data-side bridge between the memory stage and a
// synchronous data SRAM. Places store bytes on the correct lanes with
// per-byte strobes, and extracts and extends load results. The pipeline
// is stalled while a load waits out the SRAM read latency.
// Optional feature macro: MEM_ADDR_EXC_EN (flag misaligned accesses
// instead of silently aligning them).
module data_mem_bridge #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              addr_exc,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic [1:0] size_q;
  logic       sgn_q;
  logic [1:0] off_q;

  logic       is_half, is_word;
  logic [1:0] eff_off;
  logic       blocked;
  logic       accept;
  logic       load_accept;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign is_half = (req_size == 2'b01);
  assign is_word = req_size[1];

  // Lane offset actually used: halves and words are forced to alignment.
  always_comb begin
    if (is_word)      eff_off = 2'b00;
    else if (is_half) eff_off = {req_addr[1], 1'b0};
    else              eff_off = req_addr[1:0];
  end

`ifdef MEM_ADDR_EXC_EN
  logic misaligned;
  assign misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
  assign blocked    = misaligned;
  // Flag a misaligned request while it is presented in IDLE.
  assign addr_exc   = resetn && (state_q == IDLE) && req_valid && misaligned;
`else
  assign blocked    = 1'b0;
  assign addr_exc   = 1'b0;
`endif

  // NOTE: resetn gates the accept term so the SRAM-side outputs drop the
  // instant reset asserts, even while a request is still being presented.
  assign accept      = resetn && (state_q == IDLE) && req_valid && !blocked;
  assign load_accept = accept && !req_we;

  // State register.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_accept) state_d = (RD_LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latency counter and captured load attributes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= 4'd0;
      size_q <= 2'b00;
      sgn_q  <= 1'b0;
      off_q  <= 2'b00;
    end else if (load_accept) begin
      cnt_q  <= CNT_INIT;
      size_q <= req_size;
      sgn_q  <= req_signed;
      off_q  <= eff_off;
    end else if (state_q == WAIT) begin
      cnt_q  <= cnt_q - 4'd1;
    end
  end

  assign rd_byte = sram_rdata[{off_q, 3'b000} +: 8];
  assign rd_half = off_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];

  // Output decode: SRAM drive on accept, stall, and load response.
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = '0;
    sram_wdata = 32'd0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    stall      = load_accept || (state_q == WAIT);

    if (accept) begin
      sram_en   = 1'b1;
      sram_addr = {req_addr[ADDR_W-1:2], 2'b00};
      if (req_we) begin
        if (is_word) begin
          sram_wen   = 4'b1111;
          sram_wdata = req_wdata;
        end else if (is_half) begin
          sram_wen   = 4'b0011 << eff_off;
          sram_wdata = {2{req_wdata[15:0]}};
        end else begin
          sram_wen   = 4'b0001 << eff_off;
          sram_wdata = {4{req_wdata[7:0]}};
        end
      end
    end

    if (state_q == RESP) begin
      resp_valid = 1'b1;
      if (size_q == 2'b00)      resp_rdata = {{24{sgn_q & rd_byte[7]}}, rd_byte};
      else if (size_q == 2'b01) resp_rdata = {{16{sgn_q & rd_half[15]}}, rd_half};
      else                      resp_rdata = sram_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Testbench for data_mem_bridge. Three instances with read latencies 1, 3
// and 4 share one stimulus stream; each is compared against a byte-level
// reference model of lane placement and load extension.
module tb_data_mem_bridge;

  localparam int N = 3;

`ifdef MEM_ADDR_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] sram_rdata = 32'd0;

  logic        stall      [N];
  logic        resp_valid [N];
  logic [31:0] resp_rdata [N];
  logic        addr_exc   [N];
  logic        sram_en    [N];
  logic [3:0]  sram_wen   [N];
  logic [31:0] sram_addr  [N];
  logic [31:0] sram_wdata [N];

  int n_tests = 0;
  int n_fail  = 0;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_dut
      data_mem_bridge #(
        .RD_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
        .ADDR_W(32)
      ) u_dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall[g]), .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]),
        .addr_exc(addr_exc[g]), .sram_en(sram_en[g]), .sram_wen(sram_wen[g]),
        .sram_addr(sram_addr[g]), .sram_wdata(sram_wdata[g]), .sram_rdata(sram_rdata)
      );
    end
  endgenerate

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
  endfunction

  function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nbytes(size)) != 0;
  endfunction

  // First byte lane touched after rounding the offset down to the access size.
  function automatic int first_lane(input logic [1:0] size, input logic [31:0] addr);
    int n;
    n = nbytes(size);
    return (int'(addr % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_wen(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] w;
    int s, n;
    w = 4'd0;
    n = nbytes(size);
    s = first_lane(size, addr);
    for (int i = 0; i < 4; i++) if (i >= s && i < s + n) w[i] = 1'b1;
    return w;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(size);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sgn,
                                         input logic [31:0] addr, input logic [31:0] rd);
    logic [63:0] v, span;
    int n;
    n    = nbytes(size);
    v    = {32'd0, rd} >> (8 * first_lane(size, addr));
    span = 64'd1 << (8 * n);
    v    = v % span;
    if (sgn && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [73:0] obs;
    resetn = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_addr = 32'h0000_5000; req_wdata = 32'hDEAD_BEEF;
    #2;
    for (int i = 0; i < N; i++) begin
      obs = {stall[i], resp_valid[i], addr_exc[i], sram_en[i], sram_wen[i],
             sram_addr[i], sram_wdata[i]};
      n_tests++;
      if (obs !== 74'd0) begin
        n_fail++;
        $display("FAIL reset_outputs L%0d got %h want 0", lat_of(i), obs);
      end
    end
    // Release before the first rising edge with a store already presented.
    #1 resetn = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if ({sram_en[i], sram_wen[i], stall[i]} !== {1'b1, 4'b1111, 1'b0}) begin
        n_fail++;
        $display("FAIL first_accept L%0d got en=%b wen=%b stall=%b want en=1 wen=1111 stall=0",
                 lat_of(i), sram_en[i], sram_wen[i], stall[i]);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // One-cycle store; caller is just after a rising edge.
  task automatic do_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
    logic [73:0] obs, exp;
    bit blk;
    req_valid = 1'b1; req_we = 1'b1; req_size = size; req_signed = $urandom_range(0, 1);
    req_addr = addr; req_wdata = wd;
    blk = EXC && is_mis(size, addr);
    @(negedge clk);
    exp = blk ? {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0}
              : {1'b0, 1'b0, 1'b0, 1'b1, m_wen(size, addr), addr - addr % 4, m_wdata(size, wd)};
    for (int i = 0; i < N; i++) begin
      obs = {stall[i], resp_valid[i], addr_exc[i], sram_en[i], sram_wen[i],
             sram_addr[i], sram_wdata[i]};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL store L%0d size=%0d addr=%h {stall,rv,exc,en,wen,addr,wdata} got %h want %h",
                 lat_of(i), size, addr, obs, exp);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Load with req_valid held for two cycles (through RESP of the latency-1
  // instance), observed over a window covering every instance's response.
  task automatic do_load(input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] rd);
    logic [73:0] obs, exp;
    int en_cnt [N];
    int rv_cnt [N];
    bit blk;
    int l;
    for (int i = 0; i < N; i++) begin en_cnt[i] = 0; rv_cnt[i] = 0; end
    req_valid = 1'b1; req_we = 1'b0; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = $urandom; sram_rdata = rd;
    blk = EXC && is_mis(size, addr);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) req_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        l = lat_of(i);
        exp = {!blk && k < l, !blk && k == l, blk && k < 2, !blk && k == 0, 4'd0,
               (!blk && k == 0) ? addr - addr % 4 : 32'd0,
               (!blk && k == l) ? m_load(size, sgn, addr, rd) : 32'd0};
        obs = {stall[i], resp_valid[i], addr_exc[i], sram_en[i], sram_wen[i],
               sram_addr[i], resp_rdata[i]};
        en_cnt[i] += int'(sram_en[i]);
        rv_cnt[i] += int'(resp_valid[i]);
        n_tests++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL load L%0d cyc%0d size=%0d sgn=%0d addr=%h {stall,rv,exc,en,wen,addr,rdata} got %h want %h",
                   l, k, size, sgn, addr, obs, exp);
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (en_cnt[i] != (blk ? 0 : 1) || rv_cnt[i] != (blk ? 0 : 1)) begin
        n_fail++;
        $display("FAIL pulse_count L%0d got en=%0d rv=%0d want %0d each",
                 lat_of(i), en_cnt[i], rv_cnt[i], blk ? 0 : 1);
      end
    end
  endtask

  task automatic test_directed();
    do_store(2'd0, 32'h0000_1003, 32'h0000_00A5);
    do_load(2'd0, 1'b1, 32'h0000_2002, 32'h80FF_1234);
    do_load(2'd0, 1'b0, 32'h0000_2002, 32'h80FF_1234);
    do_load(2'd1, 1'b1, 32'h0000_2002, 32'h80FF_1234);
    do_store(2'd2, 32'h0000_3002, 32'h1234_5678);
    do_load(2'd3, 1'b1, 32'h0000_3001, 32'h8765_4321);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 8; j++)
      do_store(2'($urandom_range(0, 3)), $urandom, $urandom);
  endtask

  task automatic test_random_loads();
    for (int j = 0; j < 20; j++) begin
      do_load(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      do_store(2'($urandom_range(0, 3)), $urandom, $urandom);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [73:0] obs;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0000_4000; sram_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    // Latency-3/4 instances are in WAIT; assert reset with a store presented.
    resetn = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'hFFFF_FFFF;
    #1;
    for (int i = 0; i < N; i++) begin
      obs = {stall[i], resp_valid[i], addr_exc[i], sram_en[i], sram_wen[i],
             sram_addr[i], resp_rdata[i] | sram_wdata[i]};
      n_tests++;
      if (obs !== 74'd0) begin
        n_fail++;
        $display("FAIL reset_mid_load L%0d got %h want 0", lat_of(i), obs);
      end
    end
    @(negedge clk);
    req_valid = 1'b0; resetn = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if ({stall[i], resp_valid[i]} !== 2'b00) begin
          n_fail++;
          $display("FAIL dropped_load L%0d cyc%0d got stall=%b rv=%b want 0 0",
                   lat_of(i), k, stall[i], resp_valid[i]);
        end
      end
      @(posedge clk); #1;
    end
    do_load(2'd1, 1'b0, 32'h0000_4006, 32'h9ABC_DEF0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_loads();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
